// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM between two requesters with round-robin
// grant held for a whole burst transaction. Optional macro ARB_STATS_EN adds
// saturating per-port grant counters (stat_grants0/1).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; arbitrate and pass an accepted command straight through
// WR    | forwarding write beats 2..BURST_COUNT of the owning port
// RD    | routing BurstRAM read beats to the owning port until all have arrived
module burst_ram_arbiter #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4,
  parameter int STAT_BITWIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0,
  input  logic                        cmd0,
  input  logic                        cmd_en0,
  input  logic [DEPTH_BITWIDTH-1:0]   addr0,
  input  logic [DATA_BITWIDTH-1:0]    wr_data0,
  input  logic [DATA_BITWIDTH/8-1:0]  data_mask0,
  output logic [DATA_BITWIDTH-1:0]    rd_data0,
  output logic                        rd_data_valid0,
  output logic                        busy0,
  input  logic                        req1,
  input  logic                        cmd1,
  input  logic                        cmd_en1,
  input  logic [DEPTH_BITWIDTH-1:0]   addr1,
  input  logic [DATA_BITWIDTH-1:0]    wr_data1,
  input  logic [DATA_BITWIDTH/8-1:0]  data_mask1,
  output logic [DATA_BITWIDTH-1:0]    rd_data1,
  output logic                        rd_data_valid1,
  output logic                        busy1,
  output logic                        br_cmd,
  output logic                        br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]   br_addr,
  output logic [DATA_BITWIDTH-1:0]    br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]  br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]    br_rd_data,
  input  logic                        br_rd_data_valid,
  input  logic                        br_busy
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_BITWIDTH-1:0]    stat_grants0,
  output logic [STAT_BITWIDTH-1:0]    stat_grants1
`endif
);

  localparam int CNT_W  = $clog2(BURST_COUNT) + 1;
  localparam int MASK_W = DATA_BITWIDTH / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t              state, state_nxt;
  // last_grant also names the owner of the transaction in flight
  logic                last_grant, last_grant_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic                sel;
  logic                req_sel, cmd_sel, cmd_en_sel, busy_sel, accept;
  logic [DEPTH_BITWIDTH-1:0] addr_sel;
  logic [DATA_BITWIDTH-1:0]  wr_data_sel;
  logic [MASK_W-1:0]         mask_sel;

  assign rd_data0 = br_rd_data;
  assign rd_data1 = br_rd_data;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    if (req0 && req1)
      sel = ~last_grant;
    else if (req1)
      sel = 1'b1;
    else if (req0)
      sel = 1'b0;
    else
      sel = ~last_grant;
  end

  assign req_sel     = sel ? req1       : req0;
  assign cmd_sel     = sel ? cmd1       : cmd0;
  assign cmd_en_sel  = sel ? cmd_en1    : cmd_en0;
  assign addr_sel    = sel ? addr1      : addr0;
  assign wr_data_sel = sel ? wr_data1   : wr_data0;
  assign mask_sel    = sel ? data_mask1 : data_mask0;
  assign busy_sel    = br_busy | ~req_sel;
  assign accept      = (state == S_IDLE) & ~busy_sel & cmd_en_sel;

  // State, grant history and beat counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Next-state: write counts cycles from beat 2, read counts valid beats
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          last_grant_nxt = sel;
          if (cmd_sel) begin
            if (BURST_COUNT > 1) begin
              state_nxt = S_WR;
              cnt_nxt   = CNT_W'(1);
            end
          end else begin
            state_nxt = S_RD;
            cnt_nxt   = '0;
          end
        end
      end
      S_WR: begin
        if (cnt == LAST_BEAT) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RD: begin
        if (br_rd_data_valid) begin
          if (cnt == LAST_BEAT) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: gated by rst so everything is quiet while reset is held
  always_comb begin
    br_cmd         = 1'b0;
    br_cmd_en      = 1'b0;
    br_addr        = '0;
    br_wr_data     = '0;
    br_data_mask   = '0;
    rd_data_valid0 = 1'b0;
    rd_data_valid1 = 1'b0;
    busy0          = 1'b1;
    busy1          = 1'b1;
    if (rst) begin
      case (state)
        S_IDLE: begin
          if (sel)
            busy1 = busy_sel;
          else
            busy0 = busy_sel;
          if (accept) begin
            br_cmd_en    = 1'b1;
            br_cmd       = cmd_sel;
            br_addr      = addr_sel;
            br_wr_data   = wr_data_sel;
            br_data_mask = mask_sel;
          end
        end
        S_WR: begin
          br_wr_data   = last_grant ? wr_data1   : wr_data0;
          br_data_mask = last_grant ? data_mask1 : data_mask0;
        end
        S_RD: begin
          if (last_grant)
            rd_data_valid1 = br_rd_data_valid;
          else
            rd_data_valid0 = br_rd_data_valid;
        end
        default: begin
          busy0 = 1'b1;
          busy1 = 1'b1;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating count of accepted commands per port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants0 <= '0;
      stat_grants1 <= '0;
    end else if (accept) begin
      if (!sel && (stat_grants0 != '1))
        stat_grants0 <= stat_grants0 + STAT_BITWIDTH'(1);
      if (sel && (stat_grants1 != '1))
        stat_grants1 <= stat_grants1 + STAT_BITWIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural BurstRAM. Define
// ARB_STATS_EN to also check the grant counters.
module tb_burst_ram_arbiter;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BC = 4;
  localparam int SW = 16;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic                  cmd;
    logic [AW-1:0]         addr;
    logic [BC-1:0][DW-1:0] data;
    logic [MW-1:0]         mask;
  } tx_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic req0, cmd0, cmd_en0, rd_data_valid0, busy0;
  logic req1, cmd1, cmd_en1, rd_data_valid1, busy1;
  logic [AW-1:0] addr0, addr1, br_addr;
  logic [DW-1:0] wr_data0, wr_data1, rd_data0, rd_data1, br_wr_data, br_rd_data;
  logic [MW-1:0] data_mask0, data_mask1, br_data_mask;
  logic br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
`ifdef ARB_STATS_EN
  logic [SW-1:0] stat_grants0, stat_grants1;
`endif

  logic          p_req [2];
  logic          p_cmd [2];
  logic          p_cen [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];
  logic [MW-1:0] p_mask [2];

  assign req0 = p_req[0];   assign req1 = p_req[1];
  assign cmd0 = p_cmd[0];   assign cmd1 = p_cmd[1];
  assign cmd_en0 = p_cen[0]; assign cmd_en1 = p_cen[1];
  assign addr0 = p_addr[0]; assign addr1 = p_addr[1];
  assign wr_data0 = p_wd[0]; assign wr_data1 = p_wd[1];
  assign data_mask0 = p_mask[0]; assign data_mask1 = p_mask[1];

  always #5 clk = ~clk;

  burst_ram_arbiter #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW), .BURST_COUNT(BC), .STAT_BITWIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .cmd_en0(cmd_en0), .addr0(addr0), .wr_data0(wr_data0),
    .data_mask0(data_mask0), .rd_data0(rd_data0), .rd_data_valid0(rd_data_valid0), .busy0(busy0),
    .req1(req1), .cmd1(cmd1), .cmd_en1(cmd_en1), .addr1(addr1), .wr_data1(wr_data1),
    .data_mask1(data_mask1), .rd_data1(rd_data1), .rd_data_valid1(rd_data_valid1), .busy1(busy1),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .br_busy(br_busy)
`ifdef ARB_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd = 1'b0;

  // requester side
  tx_t q0[$], q1[$];
  tx_t cur [2];
  bit  has [2];
  bit  act [2];
  int  wbeat [2];

  // arbiter model: transaction level
  int m_owner, m_left, m_last;
  bit m_write;
  int m_grants [2];
  int m_wait [2];
  int order[$];
  logic [AW-1:0] acc_addr[$];

  // port-level memory image and expected read words
  logic [DW-1:0] sh [256];
  logic [DW-1:0] ex0[$], ex1[$], cap0[$], cap1[$];

  // BurstRAM model
  logic [DW-1:0] mem [256];
  int r_op, r_beat;
  logic [AW-1:0] r_addr;

  logic [DW-1:0] t1_exp [4] = '{64'hC0DE0010_10000010, 64'hC0DE0011_10000011,
                                64'hC0DE0012_10000012, 64'hC0DE0013_10000013};
  logic [DW-1:0] t2_exp [4] = '{64'h1111111111111111, 64'h2222222222222222,
                                64'h3333333333333333, 64'h4444444444444444};
  int t3_exp [4] = '{0, 1, 0, 1};
  int t4_exp [3] = '{0, 1, 0};

  function automatic void chk(string name, logic [63:0] actual, logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic logic [DW-1:0] mwrite(logic [DW-1:0] old, logic [DW-1:0] d, logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++)
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic tx_t mk_rd(logic [AW-1:0] a);
    tx_t t;
    t = '0;
    t.cmd = 1'b0;
    t.addr = a;
    return t;
  endfunction

  function automatic tx_t mk_wr(logic [AW-1:0] a, logic [BC-1:0][DW-1:0] d, logic [MW-1:0] m);
    tx_t t;
    t.cmd = 1'b1;
    t.addr = a;
    t.data = d;
    t.mask = m;
    return t;
  endfunction

  function automatic void push(int p, tx_t t);
    if (p == 0) q0.push_back(t);
    else q1.push_back(t);
  endfunction

  function automatic bit all_idle();
    return q0.size() == 0 && q1.size() == 0 && !has[0] && !has[1] && !act[0] && !act[1]
           && r_op == 0 && m_owner < 0;
  endfunction

  function automatic void clear_logs();
    order.delete(); acc_addr.delete(); cap0.delete(); cap1.delete();
  endfunction

  function automatic void reset_model();
    m_owner = -1; m_left = 0; m_last = 1; m_write = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_grants[p] = 0; m_wait[p] = 0; has[p] = 1'b0; act[p] = 1'b0; wbeat[p] = 0;
    end
    q0.delete(); q1.delete(); ex0.delete(); ex1.delete();
    r_op = 0; r_beat = 0; r_addr = '0;
    clear_logs();
  endfunction

  // compare DUT against the model for this cycle, then advance the model past the edge
  task automatic check_update();
    logic ev [2];
    logic eb [2];
    logic ecen, ecmd;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic [MW-1:0] emask;
    int w, acc;
    ev[0] = 0; ev[1] = 0; eb[0] = 1; eb[1] = 1;
    ecen = 0; ecmd = 0; eaddr = '0; ewd = '0; emask = '0; acc = -1;
    if (rst) begin
      if (m_owner < 0) begin
        if (p_req[0] && p_req[1]) w = 1 - m_last;
        else if (p_req[0]) w = 0;
        else if (p_req[1]) w = 1;
        else w = -1;
        if (w >= 0) begin
          eb[w] = br_busy;
          if (!br_busy && p_cen[w]) begin
            acc = w; ecen = 1; ecmd = p_cmd[w]; eaddr = p_addr[w]; ewd = p_wd[w]; emask = p_mask[w];
          end
        end
      end else if (m_write) begin
        ewd = p_wd[m_owner]; emask = p_mask[m_owner];
      end else begin
        ev[m_owner] = br_rd_data_valid;
      end
    end
    chk("br_cmd_en", br_cmd_en, ecen);
    chk("br_cmd", br_cmd, ecmd);
    chk("br_addr", br_addr, eaddr);
    chk("br_wr_data", br_wr_data, ewd);
    chk("br_data_mask", br_data_mask, emask);
    chk("rd_data_valid0", rd_data_valid0, ev[0]);
    chk("rd_data_valid1", rd_data_valid1, ev[1]);
    chk("busy0", busy0, eb[0]);
    chk("busy1", busy1, eb[1]);
    if (ev[0]) begin
      chk("rd_word_expected0", ex0.size() > 0, 1);
      if (ex0.size() > 0) chk("rd_data0", rd_data0, ex0.pop_front());
      cap0.push_back(rd_data0);
    end
    if (ev[1]) begin
      chk("rd_word_expected1", ex1.size() > 0, 1);
      if (ex1.size() > 0) chk("rd_data1", rd_data1, ex1.pop_front());
      cap1.push_back(rd_data1);
    end
`ifdef ARB_STATS_EN
    chk("stat_grants0", stat_grants0, (m_grants[0] > 65535) ? 65535 : m_grants[0]);
    chk("stat_grants1", stat_grants1, (m_grants[1] > 65535) ? 65535 : m_grants[1]);
`endif
    if (!rst) return;

    if (acc >= 0) begin
      order.push_back(acc);
      acc_addr.push_back(p_addr[acc]);
      m_last = acc;
      m_grants[acc]++;
      if (has[1-acc]) begin
        m_wait[1-acc]++;
        chk("fairness_wait", m_wait[1-acc] <= 1, 1);
      end
      m_wait[acc] = 0;
      has[acc] = 0; act[acc] = 1; wbeat[acc] = 1;
      m_owner = acc; m_write = p_cmd[acc];
      if (m_write) begin
        for (int i = 0; i < BC; i++)
          sh[AW'(cur[acc].addr + i)] = mwrite(sh[AW'(cur[acc].addr + i)], cur[acc].data[i], cur[acc].mask);
        m_left = BC - 1;
      end else begin
        for (int i = 0; i < BC; i++)
          if (acc == 0) ex0.push_back(sh[AW'(cur[acc].addr + i)]);
          else ex1.push_back(sh[AW'(cur[acc].addr + i)]);
        m_left = BC;
      end
      if (m_left == 0) begin act[acc] = 0; m_owner = -1; end
    end else if (m_owner >= 0) begin
      if (m_write) begin
        wbeat[m_owner]++;
        m_left--;
      end else if (br_rd_data_valid) begin
        m_left--;
      end
      if (m_left == 0) begin act[m_owner] = 0; m_owner = -1; end
    end

    // BurstRAM reacts only to what the arbiter presents
    if (br_cmd_en) begin
      r_addr = br_addr;
      if (br_cmd) begin
        mem[br_addr] = mwrite(mem[br_addr], br_wr_data, br_data_mask);
        r_op = (BC > 1) ? 1 : 0; r_beat = 1;
      end else begin
        r_op = 2; r_beat = 0;
      end
    end else if (r_op == 1) begin
      mem[AW'(r_addr + r_beat)] = mwrite(mem[AW'(r_addr + r_beat)], br_wr_data, br_data_mask);
      r_beat++;
      if (r_beat >= BC) r_op = 0;
    end else if (r_op == 2 && br_rd_data_valid) begin
      r_beat++;
      if (r_beat >= BC) r_op = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) r_op = 0;
    if (r_op == 2 && (!rnd || $urandom_range(0, 3) != 0)) begin
      br_rd_data_valid = 1'b1;
      br_rd_data = mem[AW'(r_addr + r_beat)];
    end else begin
      br_rd_data_valid = (r_op != 2) && rnd && ($urandom_range(0, 7) == 0);
      br_rd_data = {$urandom, $urandom};
    end
    br_busy = (r_op != 0) || (rnd && $urandom_range(0, 5) == 0);
    if (rst && !has[0] && !act[0] && q0.size() > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
      cur[0] = q0.pop_front(); has[0] = 1; m_wait[0] = 0;
    end
    if (rst && !has[1] && !act[1] && q1.size() > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
      cur[1] = q1.pop_front(); has[1] = 1; m_wait[1] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      p_req[p]  = 1'b0;
      p_cen[p]  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      p_cmd[p]  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      p_addr[p] = rnd ? AW'($urandom) : '0;
      p_wd[p]   = {$urandom, $urandom};
      p_mask[p] = MW'($urandom);
      if (has[p]) begin
        p_req[p]  = 1'b1;
        p_cen[p]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        p_cmd[p]  = cur[p].cmd;
        p_addr[p] = cur[p].addr;
        p_wd[p]   = cur[p].data[0];
        p_mask[p] = cur[p].mask;
      end else if (act[p]) begin
        p_req[p] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cur[p].cmd && wbeat[p] < BC) begin
          p_wd[p]   = cur[p].data[wbeat[p]];
          p_mask[p] = cur[p].mask;
        end
      end
    end
    #4;
    check_update();
  endtask

  task automatic run_idle(int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", all_idle(), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    repeat (2) cycle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tx_t t;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {32'hC0DE0000 + 32'(i), 32'h10000000 + 32'(i)};
      sh[i]  = mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_cmd[p] = 0; p_cen[p] = 0; p_addr[p] = '0; p_wd[p] = '0; p_mask[p] = '0;
    end
    br_rd_data = '0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
    reset_model();
    repeat (3) cycle();
    chk("reset_busy0", busy0, 1);
    chk("reset_busy1", busy1, 1);
    chk("reset_br_cmd_en", br_cmd_en, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: port0 read
    push(0, mk_rd(8'h10));
    run_idle(100);
    chk("t1_accepts", order.size(), 1);
    if (order.size() > 0) begin
      chk("t1_port", order[0], 0);
      chk("t1_addr", acc_addr[0], 8'h10);
    end
    chk("t1_beats", cap0.size(), 4);
    chk("t1_port1_beats", cap1.size(), 0);
    for (int i = 0; i < cap0.size() && i < 4; i++) chk("t1_word", cap0[i], t1_exp[i]);

    // 2: port1 write then port0 readback
    clear_logs();
    push(1, mk_wr(8'h20, {64'h4444444444444444, 64'h3333333333333333,
                          64'h2222222222222222, 64'h1111111111111111}, 8'hFF));
    run_idle(100);
    push(0, mk_rd(8'h20));
    run_idle(100);
    chk("t2_accepts", order.size(), 2);
    if (order.size() == 2) begin
      chk("t2_first", order[0], 1);
      chk("t2_second", order[1], 0);
    end
    chk("t2_beats", cap0.size(), 4);
    for (int i = 0; i < cap0.size() && i < 4; i++) chk("t2_readback", cap0[i], t2_exp[i]);

    // 3: both request right after reset -> alternation starting at port0
    do_reset();
    push(0, mk_rd(8'h30)); push(1, mk_rd(8'h40));
    push(0, mk_rd(8'h50)); push(1, mk_rd(8'h60));
    run_idle(200);
    chk("t3_accepts", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("t3_order", order[i], t3_exp[i]);

    // 4: port1 arrives mid-burst and beats port0's second command
    clear_logs();
    push(0, mk_rd(8'h70)); push(0, mk_rd(8'h74));
    n = 0;
    while (!(act[0] && r_op == 2 && r_beat >= 1) && n < 50) begin cycle(); n++; end
    chk("t4_reached_rd", act[0] && r_beat >= 1, 1);
    push(1, mk_rd(8'h80));
    run_idle(200);
    chk("t4_accepts", order.size(), 3);
    for (int i = 0; i < order.size() && i < 3; i++) chk("t4_order", order[i], t4_exp[i]);

    // 5: reset during read beat 2, then a clean read
    clear_logs();
    push(0, mk_rd(8'h90));
    n = 0;
    while (!(act[0] && r_op == 2 && r_beat == 1) && n < 50) begin cycle(); n++; end
    chk("t5_reached_beat2", r_beat, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_br_cmd_en", br_cmd_en, 0);
    chk("t5_br_cmd", br_cmd, 0);
    chk("t5_br_addr", br_addr, 0);
    chk("t5_br_wr_data", br_wr_data, 0);
    chk("t5_br_data_mask", br_data_mask, 0);
    chk("t5_rd_data_valid0", rd_data_valid0, 0);
    chk("t5_rd_data_valid1", rd_data_valid1, 0);
    chk("t5_busy0", busy0, 1);
    chk("t5_busy1", busy1, 1);
    reset_model();
    repeat (2) cycle();
    @(negedge clk);
    rst = 1'b1;
    push(0, mk_rd(8'h90));
    run_idle(100);
    chk("t5_beats", cap0.size(), 4);
    if (cap0.size() == 4) begin
      chk("t5_first_word", cap0[0], 64'hC0DE0090_10000090);
      chk("t5_last_word", cap0[3], 64'hC0DE0093_10000093);
    end

    // 6: 3 port0 + 2 port1 transactions
    do_reset();
    push(0, mk_rd(8'hA0)); push(0, mk_wr(8'hB0, {4{64'h0123456789ABCDEF}}, 8'h0F));
    push(0, mk_rd(8'hB0)); push(1, mk_rd(8'hC0)); push(1, mk_rd(8'hFE));
    run_idle(300);
    chk("t6_accepts", order.size(), 5);
`ifdef ARB_STATS_EN
    chk("t6_stat_grants0", stat_grants0, 3);
    chk("t6_stat_grants1", stat_grants1, 2);
`endif

    // randomized traffic
    clear_logs();
    rnd = 1'b1;
    for (int i = 0; i < 160; i++) begin
      t.cmd  = 1'($urandom_range(0, 1));
      t.addr = AW'($urandom);
      for (int b = 0; b < BC; b++) t.data[b] = {$urandom, $urandom};
      t.mask = MW'($urandom);
      push($urandom_range(0, 1), t);
    end
    run_idle(20000);
    chk("rand_accepts", order.size(), 160);
    chk("rand_reads_drained", ex0.size() + ex1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
